// File: rtl/riscv_uop_pkg.sv
// Decoded-uop types shared by Decode and the issue stage, plus the register-use helpers.
package riscv_uop_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111,
        OPC_SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    typedef struct packed {
        opcode_t     opcode;
        alu_op_t     alu_op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        uses_rs1;
        logic        is_immediate;
    } uop_t;

    typedef struct packed {
        uop_t        uop;
        logic [31:0] pc;
    } iq_entry_t;

    function automatic logic writes_rd(uop_t u);
        logic hit;
        case (u.opcode)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
            OPC_JAL, OPC_JALR, OPC_LOAD: hit = 1'b1;
            default:                     hit = 1'b0;
        endcase
        return hit && (u.rd != 5'd0);
    endfunction

    function automatic logic uses_rs2(uop_t u);
        return (u.opcode == OPC_OP) || (u.opcode == OPC_BRANCH) || (u.opcode == OPC_STORE);
    endfunction

    function automatic logic is_lsu_op(opcode_t o);
        return (o == OPC_LOAD) || (o == OPC_STORE);
    endfunction

    function automatic logic is_alu_op(opcode_t o);
        logic hit;
        case (o)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
            OPC_BRANCH, OPC_JAL, OPC_JALR: hit = 1'b1;
            default:                       hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Per-register busy bits for in-flight results; a set beats a clear on the same register, flush clears all.
module issue_scoreboard #(
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     set_en,
    input  logic [$clog2(NREGS)-1:0] set_idx,
    input  logic                     clr_en,
    input  logic [$clog2(NREGS)-1:0] clr_idx,
    output logic [NREGS-1:0]         busy
);

    localparam int RW = $clog2(NREGS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            // x0 is never tracked, so entry 0 stays clear from reset
            for (int r = 1; r < NREGS; r++) begin
                if (set_en && (set_idx == RW'(r)))      busy[r] <= 1'b1;
                else if (clr_en && (clr_idx == RW'(r))) busy[r] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/riscv_arf.sv
// Architectural register file: one write port, two combinational read ports, x0 hardwired to zero.
module riscv_arf #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] waddr,
    input  logic [XLEN-1:0]          wdata,
    input  logic [$clog2(NREGS)-1:0] raddr1,
    output logic [XLEN-1:0]          rdata1,
    input  logic [$clog2(NREGS)-1:0] raddr2,
    output logic [XLEN-1:0]          rdata2
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/issue_sb_queue.sv
// In-order DEPTH-entry issue queue with scoreboard hazard checks, branch resolution and ALU/LSU dispatch.
// Optional writeback bypass into readiness and operands: define ISSUE_WB_BYPASS_EN.
module issue_sb_queue
    import riscv_uop_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_dec_valid,
    output logic                     o_dec_ready,
    input  uop_t                     i_uop,
    input  logic [XLEN-1:0]          i_dec_pc,
    input  logic                     i_flush,
    input  logic                     i_wb_en,
    input  logic [4:0]               i_wb_rd,
    input  logic [XLEN-1:0]          i_wb_data,
    output logic                     o_branch_taken,
    output logic [XLEN-1:0]          o_branch_target,
    output logic                     o_alu_valid,
    input  logic                     i_alu_ready,
    output uop_t                     o_alu_uop,
    output logic [XLEN-1:0]          o_alu_pc,
    output logic [XLEN-1:0]          o_alu_op1,
    output logic [XLEN-1:0]          o_alu_op2,
    output logic                     o_lsu_valid,
    input  logic                     i_lsu_ready,
    output uop_t                     o_lsu_uop,
    output logic [XLEN-1:0]          o_lsu_pc,
    output logic [XLEN-1:0]          o_lsu_addr_base,
    output logic [XLEN-1:0]          o_lsu_store_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    function automatic logic branch_cond(alu_op_t op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        sa = a;
        sb = b;
        case (op)
            ALU_ADD:  return a == b;
            ALU_SUB:  return a != b;
            ALU_SLT:  return sa < sb;
            ALU_OR:   return sa >= sb;
            ALU_SLTU: return a < b;
            ALU_AND:  return a >= b;
            default:  return 1'b0;
        endcase
    endfunction

    iq_entry_t        mem [DEPTH];
    logic [AW:0]      rd_ptr, wr_ptr;
    logic             full, empty;
    iq_entry_t        head;
    uop_t             hu;
    logic [NREGS-1:0] busy;
    logic [XLEN-1:0]  arf_rs1, arf_rs2, rs1_val, rs2_val;
    logic             byp1, byp2;
    logic             head_ok, to_alu, to_lsu, drop, fire, alu_fire, pop, push, kill;
    logic [XLEN-1:0]  op1, op2, target;

    assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
    assign empty = (rd_ptr == wr_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];
    assign hu    = head.uop;

    riscv_arf #(.XLEN(XLEN), .NREGS(NREGS)) u_arf (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (i_wb_en),
        .waddr  (i_wb_rd),
        .wdata  (i_wb_data),
        .raddr1 (hu.rs1),
        .rdata1 (arf_rs1),
        .raddr2 (hu.rs2),
        .rdata2 (arf_rs2)
    );

    issue_scoreboard #(.NREGS(NREGS)) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (i_flush),
        .set_en  (fire && writes_rd(hu)),
        .set_idx (hu.rd),
        .clr_en  (i_wb_en),
        .clr_idx (i_wb_rd),
        .busy    (busy)
    );

`ifdef ISSUE_WB_BYPASS_EN
    assign byp1 = i_wb_en && (i_wb_rd != 5'd0) && (i_wb_rd == hu.rs1);
    assign byp2 = i_wb_en && (i_wb_rd != 5'd0) && (i_wb_rd == hu.rs2);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign rs1_val = byp1 ? i_wb_data : arf_rs1;
    assign rs2_val = byp2 ? i_wb_data : arf_rs2;

    // WAW uses only the registered busy bit; the bypass never frees a destination early
    assign head_ok = !empty && !i_flush
                   && (!hu.uses_rs1 || !busy[hu.rs1] || byp1)
                   && (!uses_rs2(hu) || !busy[hu.rs2] || byp2)
                   && (!writes_rd(hu) || !busy[hu.rd]);

    assign to_alu      = is_alu_op(hu.opcode);
    assign to_lsu      = is_lsu_op(hu.opcode);
    assign o_alu_valid = head_ok && to_alu;
    assign o_lsu_valid = head_ok && to_lsu;
    assign drop        = head_ok && !to_alu && !to_lsu;
    assign alu_fire    = o_alu_valid && i_alu_ready;
    assign fire        = alu_fire || (o_lsu_valid && i_lsu_ready);
    assign pop         = fire || drop;

    assign op1 = hu.uses_rs1 ? rs1_val : head.pc;
    assign op2 = ((hu.opcode == OPC_JAL) || (hu.opcode == OPC_JALR)) ? XLEN'(4)
               : hu.is_immediate ? hu.imm : rs2_val;

    assign target = (hu.opcode == OPC_JALR) ? ((rs1_val + hu.imm) & ~XLEN'(1))
                                            : (head.pc + hu.imm);
    assign kill   = alu_fire && ((hu.opcode == OPC_JAL) || (hu.opcode == OPC_JALR)
                  || ((hu.opcode == OPC_BRANCH) && branch_cond(hu.alu_op, rs1_val, rs2_val)));

    assign o_branch_taken  = kill;
    assign o_branch_target = kill ? target : '0;

    // Payloads are zeroed whenever the matching valid is low
    assign o_alu_uop        = o_alu_valid ? hu      : '0;
    assign o_alu_pc         = o_alu_valid ? head.pc : '0;
    assign o_alu_op1        = o_alu_valid ? op1     : '0;
    assign o_alu_op2        = o_alu_valid ? op2     : '0;
    assign o_lsu_uop        = o_lsu_valid ? hu      : '0;
    assign o_lsu_pc         = o_lsu_valid ? head.pc : '0;
    assign o_lsu_addr_base  = o_lsu_valid ? op1     : '0;
    assign o_lsu_store_data = o_lsu_valid ? rs2_val : '0;

    assign o_dec_ready = !full;
    assign push        = i_dec_valid && !full && !kill && !i_flush;
    assign o_count     = wr_ptr - rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (i_flush || kill) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{uop: i_uop, pc: i_dec_pc};
    end

endmodule

// File: tb/tb_issue_sb_queue.sv
// Scoreboard bench for issue_sb_queue: expected dispatches queued at push, compared on every fire.
module tb_issue_sb_queue;
    import riscv_uop_pkg::*;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_dec_valid = 1'b0;
    logic              o_dec_ready;
    uop_t              i_uop = '0;
    logic [XLEN-1:0]   i_dec_pc = '0;
    logic              i_flush = 1'b0;
    logic              i_wb_en = 1'b0;
    logic [4:0]        i_wb_rd = '0;
    logic [XLEN-1:0]   i_wb_data = '0;
    logic              o_branch_taken;
    logic [XLEN-1:0]   o_branch_target;
    logic              o_alu_valid;
    logic              i_alu_ready = 1'b0;
    uop_t              o_alu_uop;
    logic [XLEN-1:0]   o_alu_pc, o_alu_op1, o_alu_op2;
    logic              o_lsu_valid;
    logic              i_lsu_ready = 1'b0;
    uop_t              o_lsu_uop;
    logic [XLEN-1:0]   o_lsu_pc, o_lsu_addr_base, o_lsu_store_data;
    logic [$clog2(DEPTH):0] o_count;

    issue_sb_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_dec_valid(i_dec_valid), .o_dec_ready(o_dec_ready), .i_uop(i_uop), .i_dec_pc(i_dec_pc),
        .i_flush(i_flush), .i_wb_en(i_wb_en), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
        .o_branch_taken(o_branch_taken), .o_branch_target(o_branch_target),
        .o_alu_valid(o_alu_valid), .i_alu_ready(i_alu_ready), .o_alu_uop(o_alu_uop),
        .o_alu_pc(o_alu_pc), .o_alu_op1(o_alu_op1), .o_alu_op2(o_alu_op2),
        .o_lsu_valid(o_lsu_valid), .i_lsu_ready(i_lsu_ready), .o_lsu_uop(o_lsu_uop),
        .o_lsu_pc(o_lsu_pc), .o_lsu_addr_base(o_lsu_addr_base), .o_lsu_store_data(o_lsu_store_data),
        .o_count(o_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        uop_t        uop;
        logic [31:0] pc;
    } exp_t;

    exp_t        expq[$];
    exp_t        mon_e;
    logic [31:0] marf [NREGS];
    logic [31:0] m_op1, m_op2;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic uop_t mk(opcode_t opc, alu_op_t op, int rd, int rs1, int rs2,
                                logic [31:0] imm, bit u1, bit isimm);
        uop_t u;
        u = '0;
        u.opcode       = opc;
        u.alu_op       = op;
        u.rd           = 5'(rd);
        u.rs1          = 5'(rs1);
        u.rs2          = 5'(rs2);
        u.imm          = imm;
        u.uses_rs1     = u1;
        u.is_immediate = isimm;
        return u;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input uop_t u, input logic [31:0] pc, input bit exp_fire);
        i_dec_valid = 1'b1;
        i_uop       = u;
        i_dec_pc    = pc;
        if (exp_fire) expq.push_back('{u, pc});
        tick();
        i_dec_valid = 1'b0;
    endtask

    task automatic wb(input int rd, input logic [31:0] data);
        i_wb_en   = 1'b1;
        i_wb_rd   = 5'(rd);
        i_wb_data = data;
        marf[rd]  = data;
        tick();
        i_wb_en   = 1'b0;
    endtask

    task automatic clean();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
    endtask

    // Reference dispatch model: FIFO order, routing and operands from the bench's own register copy
    always @(negedge clk) begin
        if (rst_n && ((o_alu_valid && i_alu_ready) || (o_lsu_valid && i_lsu_ready))) begin
            if (expq.size() == 0) begin
                check("unexpected_fire", 64'd1, 64'd0);
            end else begin
                mon_e = expq.pop_front();
                m_op1 = mon_e.uop.uses_rs1 ? marf[mon_e.uop.rs1] : mon_e.pc;
                m_op2 = ((mon_e.uop.opcode == OPC_JAL) || (mon_e.uop.opcode == OPC_JALR)) ? 32'd4
                      : mon_e.uop.is_immediate ? mon_e.uop.imm : marf[mon_e.uop.rs2];
                if ((mon_e.uop.opcode == OPC_LOAD) || (mon_e.uop.opcode == OPC_STORE)) begin
                    check("route_lsu", {o_alu_valid, o_lsu_valid}, 2'b01);
                    check("lsu_uop", o_lsu_uop, mon_e.uop);
                    check("lsu_pc", o_lsu_pc, mon_e.pc);
                    check("lsu_addr", o_lsu_addr_base, m_op1);
                    check("lsu_sdata", o_lsu_store_data, marf[mon_e.uop.rs2]);
                end else begin
                    check("route_alu", {o_alu_valid, o_lsu_valid}, 2'b10);
                    check("alu_uop", o_alu_uop, mon_e.uop);
                    check("alu_pc", o_alu_pc, mon_e.pc);
                    check("alu_op1", o_alu_op1, m_op1);
                    check("alu_op2", o_alu_op2, m_op2);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < NREGS; r++) marf[r] = '0;

        #12;
        check("rst_count", o_count, 0);
        check("rst_dec_ready", o_dec_ready, 1);
        check("rst_valids", {o_alu_valid, o_lsu_valid, o_branch_taken}, 3'b000);
        check("rst_alu_op1", o_alu_op1, 0);
        check("rst_lsu_addr", o_lsu_addr_base, 0);
        check("rst_target", o_branch_target, 0);
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_count", o_count, 0);
        check("post_rst_dec_ready", o_dec_ready, 1);

        wb(1, 32'd3);
        wb(2, 32'd3);
        wb(3, 32'h2003);
        wb(4, 32'hFFFF_FFF0);

        // Fill with both readies low, then drain in order
        for (int i = 0; i < 4; i++)
            push_one(mk(OPC_OP_IMM, ALU_ADD, 10 + i, 0, 0, 32'(i + 1), 1, 1), 32'h40 + 32'(4 * i), 1);
        #1;
        check("fill_count", o_count, 4);
        check("fill_dec_ready", o_dec_ready, 0);
        check("fill_head_valid", o_alu_valid, 1);
        i_alu_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_valid", o_alu_valid, 1);
            check("drain_count", o_count, 64'(4 - i));
            tick();
        end
        #1;
        check("drained_count", o_count, 0);
        check("drained_valid", o_alu_valid, 0);
        clean();

        // RAW on a load result
        i_lsu_ready = 1'b1;
        push_one(mk(OPC_LOAD, ALU_ADD, 5, 1, 0, 32'd0, 1, 1), 32'h200, 1);
        push_one(mk(OPC_OP, ALU_ADD, 6, 5, 1, 32'd0, 1, 0), 32'h204, 1);
        #1;
        check("raw_stall0", o_alu_valid, 0);
        tick();
        check("raw_stall1", o_alu_valid, 0);
        i_wb_en = 1'b1; i_wb_rd = 5'd5; i_wb_data = 32'h10; marf[5] = 32'h10;
        #1;
`ifdef ISSUE_WB_BYPASS_EN
        check("raw_bypass_fire", o_alu_valid, 1);
        check("raw_bypass_op1", o_alu_op1, 32'h10);
        tick();
        i_wb_en = 1'b0;
`else
        check("raw_wb_cycle", o_alu_valid, 0);
        tick();
        i_wb_en = 1'b0;
        #1;
        check("raw_after_wb", o_alu_valid, 1);
        check("raw_after_wb_op1", o_alu_op1, 32'h10);
        tick();
`endif
        #1;
        check("raw_done", o_alu_valid, 0);
        clean();

        // WAW on x7
        push_one(mk(OPC_OP_IMM, ALU_ADD, 7, 0, 0, 32'd5, 1, 1), 32'h300, 1);
        push_one(mk(OPC_OP_IMM, ALU_ADD, 7, 0, 0, 32'd6, 1, 1), 32'h304, 1);
        #1;
        check("waw_push_pop_count", o_count, 1);
        check("waw_blocked0", o_alu_valid, 0);
        tick();
        check("waw_blocked1", o_alu_valid, 0);
        i_wb_en = 1'b1; i_wb_rd = 5'd7; i_wb_data = 32'h55; marf[7] = 32'h55;
        #1;
        check("waw_wb_cycle", o_alu_valid, 0);
        tick();
        i_wb_en = 1'b0;
        #1;
        check("waw_release", o_alu_valid, 1);
        tick();
        clean();

        // Taken branch kills younger entries and a concurrent push
        i_alu_ready = 1'b0;
        push_one(mk(OPC_BRANCH, ALU_ADD, 0, 1, 2, 32'h20, 1, 0), 32'h100, 1);
        push_one(mk(OPC_OP_IMM, ALU_ADD, 8, 0, 0, 32'd1, 1, 1), 32'h104, 0);
        push_one(mk(OPC_OP_IMM, ALU_ADD, 9, 0, 0, 32'd2, 1, 1), 32'h108, 0);
        i_alu_ready = 1'b1;
        i_dec_valid = 1'b1;
        i_uop       = mk(OPC_OP_IMM, ALU_ADD, 11, 0, 0, 32'd3, 1, 1);
        i_dec_pc    = 32'h10c;
        #1;
        check("beq_taken", o_branch_taken, 1);
        check("beq_target", o_branch_target, 32'h120);
        check("beq_count", o_count, 3);
        tick();
        i_dec_valid = 1'b0;
        #1;
        check("kill_count", o_count, 0);
        check("kill_valid", o_alu_valid, 0);
        check("kill_taken_low", o_branch_taken, 0);

        // Other branch conditions
        push_one(mk(OPC_BRANCH, ALU_SUB, 0, 1, 2, 32'h40, 1, 0), 32'h140, 1);
        #1;
        check("bne_valid", o_alu_valid, 1);
        check("bne_not_taken", o_branch_taken, 0);
        tick();
        push_one(mk(OPC_BRANCH, ALU_SLT, 0, 4, 1, 32'h10, 1, 0), 32'h180, 1);
        #1;
        check("blt_taken", o_branch_taken, 1);
        check("blt_target", o_branch_target, 32'h190);
        tick();
        push_one(mk(OPC_BRANCH, ALU_SLTU, 0, 4, 1, 32'h10, 1, 0), 32'h1c0, 1);
        #1;
        check("bltu_not_taken", o_branch_taken, 0);
        tick();

        // Jumps
        push_one(mk(OPC_JALR, ALU_ADD, 0, 3, 0, 32'd0, 1, 1), 32'h400, 1);
        #1;
        check("jalr_taken", o_branch_taken, 1);
        check("jalr_target", o_branch_target, 32'h2002);
        check("jalr_op2", o_alu_op2, 32'd4);
        tick();
        push_one(mk(OPC_JAL, ALU_ADD, 0, 0, 0, 32'h40, 0, 1), 32'h500, 1);
        #1;
        check("jal_target", o_branch_target, 32'h540);
        tick();

        // Unroutable opcode is dropped silently
        push_one(mk(OPC_SYSTEM, ALU_ADD, 0, 0, 0, 32'd0, 0, 0), 32'h580, 0);
        #1;
        check("drop_no_valid", {o_alu_valid, o_lsu_valid}, 2'b00);
        tick();
        check("drop_count", o_count, 0);

        // Flush while entries wait behind a busy register
        i_alu_ready = 1'b0;
        push_one(mk(OPC_LOAD, ALU_ADD, 5, 1, 0, 32'd0, 1, 1), 32'h600, 1);
        push_one(mk(OPC_OP_IMM, ALU_ADD, 21, 0, 0, 32'd1, 1, 1), 32'h604, 0);
        push_one(mk(OPC_OP, ALU_ADD, 6, 5, 1, 32'd0, 1, 0), 32'h608, 0);
        push_one(mk(OPC_OP_IMM, ALU_ADD, 22, 0, 0, 32'd2, 1, 1), 32'h60c, 0);
        #1;
        check("pre_flush_count", o_count, 3);
        check("pre_flush_valid", o_alu_valid, 1);
        i_flush = 1'b1;
        #1;
        check("flush_valids", {o_alu_valid, o_lsu_valid, o_branch_taken}, 3'b000);
        tick();
        i_flush = 1'b0;
        #1;
        check("post_flush_count", o_count, 0);
        i_alu_ready = 1'b1;
        push_one(mk(OPC_OP, ALU_ADD, 6, 5, 1, 32'd0, 1, 0), 32'h610, 1);
        #1;
        check("post_flush_dep_issue", o_alu_valid, 1);
        tick();
        tick();

        check("expected_all_fired", 64'(expq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/issue_sb_queue.md
# issue_sb_queue

Parametrised successor to the single-slot issue stage: a DEPTH-entry in-order issue queue between Decode and the ALU/LSU with a per-register scoreboard. It holds decoded uops, blocks the head on RAW/WAW hazards against in-flight results, and reads operands from an internal ARF. It resolves branches and jumps at issue and dispatches over valid/ready handshakes to ALU or LSU.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- XLEN, 32: datapath width.
- NREGS, 32: architectural registers; x0 is never tracked.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_dec_valid / o_dec_ready  in/out  1  Decode handshake; o_dec_ready = !full.
- i_uop  in  uop_t  decoded uop.
- i_dec_pc  in  XLEN  PC of i_uop.
- i_flush  in  1  synchronous kill of the queue and scoreboard.
- i_wb_en, i_wb_rd, i_wb_data  in  1/5/XLEN  writeback to ARF; clears scoreboard.
- o_branch_taken, o_branch_target  out  1/XLEN  redirect to Fetch.
- o_alu_valid / i_alu_ready  out/in  1  ALU handshake.
- o_alu_uop, o_alu_pc, o_alu_op1, o_alu_op2  out  uop_t/XLEN/XLEN/XLEN.
- o_lsu_valid / i_lsu_ready  out/in  1  LSU handshake.
- o_lsu_uop, o_lsu_pc, o_lsu_addr_base, o_lsu_store_data  out  uop_t/XLEN/XLEN/XLEN.
- o_count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Circular buffer with rd_ptr/wr_ptr carrying one extra wrap bit. Full when the index bits match and the wrap bits differ. Empty when the pointers are equal.
- Push when i_dec_valid && o_dec_ready && !kill. Pop on dispatch fire, where fire = (o_alu_valid&&i_alu_ready) || (o_lsu_valid&&i_lsu_ready).
- Register-use rules:
  - writes_rd: opcode in {OP, OP_IMM, LUI, AUIPC, JAL, JALR, LOAD} and rd≠0.
  - uses_rs2: opcode in {OP, BRANCH, STORE}.
  - uses_rs1: taken from uop.uses_rs1.
- Head is eligible when all of the following hold:
  - the queue is not empty and i_flush is low;
  - every source in use is not busy, unless that source is bypassed (see Configuration);
  - for writes_rd, rd is not busy (WAW).
- Routing:
  - LOAD/STORE go to the LSU.
  - OP, OP_IMM, LUI, AUIPC, BRANCH, JAL and JALR go to the ALU.
  - Any other opcode is dropped: popped with no valid raised.
  - Only one unit's valid is raised per cycle.
- Operands:
  - op1 = uses_rs1 ? rs1 : pc.
  - op2 = JAL/JALR ? 4 : is_immediate ? imm : rs2.
  - LSU address base = op1; LSU store data = rs2.
- Scoreboard:
  - Set busy[rd] on fire of a writes_rd uop.
  - Clear busy[i_wb_rd] on i_wb_en.
  - If set and clear hit the same register in one cycle, set wins.
- Branch compare, selected by alu_op:
  - ADD = BEQ, SUB = BNE, SLT = signed <, OR = signed ≥, SLTU = unsigned <, AND = unsigned ≥.
  - Branch target = pc+imm.
  - JAL is always taken, target pc+imm. JALR is always taken, target (rs1+imm)&~1.
- o_branch_taken pulses only in the cycle a taken BRANCH/JAL/JALR fires. Kill = that pulse.
- Kill behaviour:
  - Drops every younger entry; the next cycle the queue is empty.
  - Blocks any push in the same cycle.
  - Leaves the scoreboard intact, since older results are still in flight.
- i_flush behaviour:
  - Empties the queue and clears all scoreboard bits next cycle.
  - Forces both valids and o_branch_taken low in the same cycle.

## Timing
- Reset values:
  - Queue empty; o_count=0; o_dec_ready=1; scoreboard all clear.
  - o_alu_valid, o_lsu_valid and o_branch_taken = 0; all data outputs = 0.
- Latency: a uop pushed in cycle N into an empty queue is presented in cycle N+1, if hazard-free.
- Handshakes:
  - Once raised, valid and payload stay stable until ready, except when i_flush is asserted.
  - Valid never depends combinationally on ready. o_dec_ready never depends on downstream ready.
- Throughput: one dispatch per cycle. Push and pop in the same cycle leave o_count unchanged.
- Pointer wrap at DEPTH keeps full/empty correct.
- Reset mid-operation drops all state immediately.

## Configuration
- ISSUE_WB_BYPASS_EN defined:
  - A source equal to i_wb_rd under i_wb_en (rd≠0) counts as ready in that cycle.
  - i_wb_data is forwarded into the operands and the branch compare.
- ISSUE_WB_BYPASS_EN undefined:
  - Readiness uses the registered busy bit only.
  - A dependent uop issues at the earliest one cycle after writeback and reads the ARF.

## Structure
- Add to riscv_uop_pkg:
  - iq_entry_t {uop_t uop; logic [31:0] pc};
  - functions writes_rd(uop_t) and uses_rs2(uop_t).
- Instantiate the existing ARF with combinational read.
- One sub-module: issue_scoreboard (NREGS busy bits, set/clear ports, set-wins priority, flush-clear).

## Test plan
- Fill and drain: push 4 ADDIs with both readies held low → o_dec_ready=0 at o_count=4. Release ready → 4 fires in order, one per cycle; o_count ends at 0.
- RAW stall: LW x5 fires, then ADD x6,x5,x1 waits at head.
  - With i_wb_en, rd=5, data=0x10 and the macro on: it fires in the same cycle with op1=0x10.
  - With the macro off: it fires one cycle later.
- WAW: ADDI x7 in flight, next ADDI x7 → blocked until wb rd=7.
- Taken branch: BEQ x1,x2 with x1=x2=3, pc=0x100, imm=0x20, with 2 younger entries queued → o_branch_taken=1, target=0x120. Queue empty next cycle; a concurrent decode push is dropped.
- JALR: rs1=0x2003, imm=0 → target 0x2002; op2=4 on the ALU port.
- Flush mid-stall: 3 entries queued, busy x5 set, i_flush → both valids drop that cycle. Next cycle o_count=0 and a dependent on x5 issues immediately.
